// File: rtl/baud_tick_gen.sv
// Fractional-N baud tick generator: oversample tick plus mid-bit and bit-boundary strobes,
// with a shadowed runtime divisor and a phase resync input.
module baud_tick_gen #(
  parameter int unsigned NB_DIV           = 16,
  parameter int unsigned NB_FRAC          = 4,
  parameter int unsigned OVERSAMPLE       = 16,
  parameter int unsigned NB_OS            = 4,
  parameter int unsigned DEFAULT_DIV_INT  = 326,
  parameter int unsigned DEFAULT_DIV_FRAC = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_sync,
  input  logic               i_div_load,
  input  logic [NB_DIV-1:0]  i_div_int,
  input  logic [NB_FRAC-1:0] i_div_frac,
  output logic               o_tick,
  output logic               o_mid_tick,
  output logic               o_bit_tick,
  output logic               o_div_pending,
  output logic               o_div_err
);

  localparam logic [NB_DIV-1:0]  DefDivInt  = NB_DIV'(DEFAULT_DIV_INT);
  localparam logic [NB_FRAC-1:0] DefDivFrac = NB_FRAC'(DEFAULT_DIV_FRAC);
  localparam logic [NB_OS-1:0]   OsMid      = NB_OS'(OVERSAMPLE / 2 - 1);
  localparam logic [NB_OS-1:0]   OsLast     = NB_OS'(OVERSAMPLE - 1);

  logic [NB_DIV-1:0]  div_int_q, div_int_d;
  logic [NB_FRAC-1:0] div_frac_q, div_frac_d;
  logic [NB_DIV-1:0]  shd_int_q, shd_int_d;
  logic [NB_FRAC-1:0] shd_frac_q, shd_frac_d;
  logic [NB_DIV-1:0]  cnt_q, cnt_d;
  logic [NB_FRAC-1:0] acc_q, acc_d;
  logic               ext_q, ext_d;
  logic [NB_OS-1:0]   os_cnt_q, os_cnt_d;
  logic               pending_q, pending_d;
  logic               err_q, err_d;

  logic [NB_DIV-1:0]  term;
  logic               at_term;
  logic               tick;
  logic               load_ok;
  logic               load_bad;
  logic               apply;
  logic [NB_FRAC:0]   frac_sum;

  // ext stretches the current period by one cycle when the previous tick carried.
  assign term     = div_int_q - NB_DIV'(1) + NB_DIV'(ext_q);
  assign at_term  = (cnt_q == term);
  assign tick     = i_enable & ~i_sync & ~i_reset & at_term;
  assign load_ok  = i_div_load & (i_div_int >= NB_DIV'(2));
  assign load_bad = i_div_load & (i_div_int < NB_DIV'(2));
  assign apply    = pending_q & (tick | i_sync | ~i_enable);
  assign frac_sum = {1'b0, acc_q} + {1'b0, div_frac_q};

  assign o_tick        = tick;
  assign o_mid_tick    = tick & (os_cnt_q == OsMid);
  assign o_bit_tick    = tick & (os_cnt_q == OsLast);
  assign o_div_pending = pending_q;
  assign o_div_err     = err_q;

  always_comb begin
    cnt_d      = cnt_q;
    os_cnt_d   = os_cnt_q;
    acc_d      = acc_q;
    ext_d      = ext_q;
    div_int_d  = div_int_q;
    div_frac_d = div_frac_q;
    shd_int_d  = shd_int_q;
    shd_frac_d = shd_frac_q;
    pending_d  = pending_q;
    err_d      = load_bad;

    if (i_sync) begin
      cnt_d    = '0;
      os_cnt_d = '0;
      acc_d    = '0;
      ext_d    = 1'b0;
    end else begin
      if (i_enable) begin
        cnt_d = at_term ? '0 : cnt_q + NB_DIV'(1);
      end
      if (tick) begin
        os_cnt_d = os_cnt_q + NB_OS'(1);
      end
      // A new divisor restarts the fractional phase from zero.
      if (apply) begin
        acc_d = '0;
        ext_d = 1'b0;
      end else if (tick) begin
        acc_d = frac_sum[NB_FRAC-1:0];
        ext_d = frac_sum[NB_FRAC];
      end
    end

    if (apply) begin
      div_int_d  = shd_int_q;
      div_frac_d = shd_frac_q;
      pending_d  = 1'b0;
    end
    // A load coinciding with an apply lands in the shadow after the old shadow moved out.
    if (load_ok) begin
      shd_int_d  = i_div_int;
      shd_frac_d = i_div_frac;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_int_q  <= DefDivInt;
      div_frac_q <= DefDivFrac;
      shd_int_q  <= DefDivInt;
      shd_frac_q <= DefDivFrac;
      cnt_q      <= '0;
      acc_q      <= '0;
      ext_q      <= 1'b0;
      os_cnt_q   <= '0;
      pending_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      div_int_q  <= div_int_d;
      div_frac_q <= div_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ext_q      <= ext_d;
      os_cnt_q   <= os_cnt_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: stimulus queues expected tick/error cycles, a negedge
// monitor pops and compares them whenever the DUT strobes.
module tb_baud_tick_gen;

  logic        i_clk;
  logic        i_reset;
  logic        i_enable;
  logic        i_sync;
  logic        i_div_load;
  logic [15:0] i_div_int;
  logic [3:0]  i_div_frac;
  logic        o_tick;
  logic        o_mid_tick;
  logic        o_bit_tick;
  logic        o_div_pending;
  logic        o_div_err;

  baud_tick_gen dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_sync        (i_sync),
    .i_div_load    (i_div_load),
    .i_div_int     (i_div_int),
    .i_div_frac    (i_div_frac),
    .o_tick        (o_tick),
    .o_mid_tick    (o_mid_tick),
    .o_bit_tick    (o_bit_tick),
    .o_div_pending (o_div_pending),
    .o_div_err     (o_div_err)
  );

  typedef struct {
    int c;
    bit m;
    bit b;
  } exp_t;

  exp_t exp_q[$];
  int   err_exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   tidx  = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Tick index since the last phase reset decides the mid/bit strobes (x16 oversample).
  task automatic push_tick(input int c);
    exp_t e;
    e.c = c;
    e.m = ((tidx % 16) == 7);
    e.b = ((tidx % 16) == 15);
    exp_q.push_back(e);
    tidx++;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic pulse_load(input int di, input int df);
    i_div_int  = 16'(di);
    i_div_frac = 4'(df);
    i_div_load = 1'b1;
    @(posedge i_clk);
    #1;
    i_div_load = 1'b0;
  endtask

  task automatic pulse_sync();
    i_sync = 1'b1;
    #2;
    chk("sync_suppress", o_tick, 0);
    @(posedge i_clk);
    #1;
    i_sync = 1'b0;
  endtask

  exp_t me;
  always @(negedge i_clk) begin
    if (o_tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tick_unexpected: got tick at cycle %0d expected none", cyc);
      end else begin
        me = exp_q.pop_front();
        chk("tick_cycle", cyc, me.c);
        chk("tick_mid", o_mid_tick, me.m);
        chk("tick_bit", o_bit_tick, me.b);
      end
    end else if (o_mid_tick === 1'b1 || o_bit_tick === 1'b1) begin
      total++;
      bad++;
      $display("FAIL strobe_without_tick: got mid=%0b bit=%0b expected 0", o_mid_tick, o_bit_tick);
    end
    if (o_div_err === 1'b1) begin
      if (err_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL err_unexpected: got err at cycle %0d expected none", cyc);
      end else begin
        chk("err_cycle", cyc, err_exp_q.pop_front());
      end
    end
  end

  int t0, c, nt, s, s2, q, t1, len;

  initial begin
    i_reset    = 1'b1;
    i_enable   = 1'b0;
    i_sync     = 1'b0;
    i_div_load = 1'b0;
    i_div_int  = '0;
    i_div_frac = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_tick", o_tick, 0);
    chk("reset_pending", o_div_pending, 0);
    chk("reset_err", o_div_err, 0);

    // Default 326/0: ticks every 326 cycles, first at cycle 325.
    i_reset  = 1'b0;
    i_enable = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 16; k++) push_tick(t0 + 325 + 326 * k);
    wait_until(t0 + 5216);
    chk("idle_pending", o_div_pending, 0);

    // 325 + 8/16: apply on the next tick, then periods 325,325,326,325,326,...
    c = cyc;
    nt = c + 325;
    push_tick(nt);
    for (int j = 0; j < 31; j++) begin
      len = 325 + ((j == 0) ? 0 : ((8 * j) / 16 - (8 * (j - 1)) / 16));
      nt = nt + len;
      push_tick(nt);
    end
    pulse_load(325, 8);
    chk("frac_pending_set", o_div_pending, 1);
    wait_until(c + 325);
    chk("frac_pending_at_tick", o_div_pending, 1);
    wait_until(c + 326);
    chk("frac_pending_clr", o_div_pending, 0);
    wait_until(nt + 1);

    // Restore 326/0 via a sync, then illegal loads.
    pulse_load(326, 0);
    s = cyc;
    tidx = 0;
    push_tick(s + 326);
    push_tick(s + 652);
    pulse_sync();
    chk("sync_apply_pending", o_div_pending, 0);
    wait_until(s + 11);
    err_exp_q.push_back(cyc + 1);
    pulse_load(1, 3);
    chk("bad1_pending", o_div_pending, 0);
    wait_until(s + 31);
    err_exp_q.push_back(cyc + 1);
    pulse_load(0, 0);
    chk("bad0_pending", o_div_pending, 0);

    // Freeze at cnt=100 for 50 cycles; tick resumes 225 cycles after re-enable.
    push_tick(s + 1028);
    push_tick(s + 1354);
    push_tick(s + 1680);
    push_tick(s + 2006);
    push_tick(s + 2332);
    wait_until(s + 753);
    i_enable = 1'b0;
    wait_until(s + 803);
    i_enable = 1'b1;

    // Sync at cnt=200, os_cnt=7 with 300 pending: next tick 300 later, os_cnt restarted.
    wait_until(s + 2400);
    pulse_load(300, 0);
    wait_until(s + 2533);
    s2 = cyc;
    tidx = 0;
    push_tick(s2 + 300);
    pulse_sync();
    chk("sync_pending_clr", o_div_pending, 0);

    // Last load wins; load on a tick cycle waits for the following tick.
    q = s2 + 301;
    push_tick(q + 299);
    push_tick(q + 499);
    push_tick(q + 699);
    push_tick(q + 849);
    push_tick(q + 999);
    push_tick(q + 1119);
    push_tick(q + 1299);
    wait_until(q + 5);
    pulse_load(100, 0);
    wait_until(q + 10);
    pulse_load(200, 0);
    wait_until(q + 499);
    pulse_load(150, 0);
    chk("tick_load_pending", o_div_pending, 1);
    wait_until(q + 700);
    chk("tick_load_applied", o_div_pending, 0);
    wait_until(q + 860);
    pulse_load(120, 0);
    wait_until(q + 999);
    pulse_load(180, 0);
    chk("load_apply_same_cycle", o_div_pending, 1);
    wait_until(q + 1120);
    chk("second_apply", o_div_pending, 0);

    // Sync exactly on a terminal cycle suppresses that tick.
    wait_until(q + 1479);
    tidx = 0;
    push_tick(q + 1659);
    pulse_sync();

    // Disable with a pending divisor applies it while the counter holds at 50.
    push_tick(q + 1914);
    wait_until(q + 1700);
    pulse_load(250, 0);
    wait_until(q + 1710);
    i_enable = 1'b0;
    @(posedge i_clk);
    #1;
    chk("disabled_apply", o_div_pending, 0);
    wait_until(q + 1715);
    i_enable = 1'b1;

    // Reset with a load pending discards it.
    wait_until(q + 1950);
    pulse_load(500, 0);
    chk("pre_reset_pending", o_div_pending, 1);
    wait_until(q + 1960);
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("mid_reset_pending", o_div_pending, 0);
    chk("mid_reset_tick", o_tick, 0);
    i_reset = 1'b0;
    t1 = cyc;
    tidx = 0;
    push_tick(t1 + 325);
    push_tick(t1 + 651);
    wait_until(t1 + 700);

    while (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL tick_missing: got none expected tick at cycle %0d", me.c);
    end
    while (err_exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL err_missing: got none expected err at cycle %0d", err_exp_q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
